ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//   Execute stage directly downstream of the ID decoder. Holds the ID/EX pipeline register and
//   computes logic and shift results in one cycle. Runs DIV/DIVU on a multi-cycle radix-2
//   restoring divider that writes HI/LO. Feeds EX/MEM and drives the ex_* forwarding inputs of ID.
// PARAMETERS
//   DIV_CYCLES  32  iterations of the divider; one quotient bit per cycle.
// PORTS
//   clk          in   1  clock.
//   rst          in   1  reset: synchronous, active-high.
//   stall_i      in   1  downstream hold; the ID/EX register keeps its value.
//   flush_i      in   1  load a bubble into ID/EX and abort any division.
//   id_alusel_i  in   3  `AluSelBus from ID.
//   id_aluop_i   in   8  `AluOpBus from ID.
//   id_reg1_i    in  32  operand 1 (rs, or rt for shifts).
//   id_reg2_i    in  32  operand 2 (rt, imm32, or shift amount).
//   id_waddr_i   in   5  destination register.
//   id_wreg_i    in   1  write enable.
//   ex_wreg_o    out  1  to EX/MEM and ID forwarding.
//   ex_waddr_o   out  5  to EX/MEM and ID forwarding.
//   ex_wdata_o   out 32  to EX/MEM and ID forwarding.
//   stall_req_o  out  1  request to freeze PC, IF/ID and ID/EX.
//   hi_o         out 32  HI register.
//   lo_o         out 32  LO register.
// BEHAVIOUR
// - Reset:
//     ID/EX fields = NOP (`ALU_NOP_OP, `ALU_RES_NOP, waddr 0, wreg 0, data 0).
//     FSM = IDLE; hi_o = lo_o = 0; outputs 0; stall_req_o = 0.
// - ID/EX load priority, evaluated at each posedge:
//     1. rst
//     2. flush_i: load a bubble.
//     3. stall_i or stall_req_o: hold.
//     4. otherwise: load the id_* inputs.
// - Outputs are combinational from ID/EX: ex_wreg_o = wreg, ex_waddr_o = waddr. Latency from ID is one cycle.
// - ex_wdata_o by alusel:
//     LOGIC: AND, OR, XOR, NOR of reg1 and reg2.
//     SHIFT: reg1 shifted by reg2[4:0]. SLL / SRL are logical; SRA replicates bit 31.
//     NOP or any other value: 0.
// - DIV/DIVU (`ALU_DIV_OP, `ALU_DIVU_OP): ex_wreg_o is forced to 0; only HI/LO are written.
// - Divider FSM:
//     IDLE: on a div op with flush_i = 0, go to BUSY, or to DONE if the divisor is 0.
//           Latch |dividend| and |divisor| (DIVU uses raw values). Clear the counter.
//     BUSY: shift the partial remainder; subtract if >= divisor; the quotient bit = 1 on
//           subtract. Counter++. At DIV_CYCLES-1, go to DONE.
//     DONE: apply signs and write HI/LO on this edge. Go to IDLE. The ID/EX register advances this same edge.
// - stall_req_o = (IDLE and a div op present) or BUSY. DONE deasserts it.
//   Nonzero divide stalls 33 cycles; the result is visible on hi_o/lo_o 34 cycles after the op enters EX.
// - Sign rules:
//     DIV quotient is negated if the operand signs differ.
//     DIV remainder takes the sign of the dividend.
//     The 0x80000000 / -1 case wraps: LO = 0x80000000, HI = 0.
// - Divide by zero: 1-cycle stall; LO = 32'hFFFF_FFFF, HI = dividend.
// - flush_i during BUSY or DONE: FSM goes to IDLE; HI/LO are not written; stall_req_o drops the next cycle.
// - rst mid-division: same as flush_i, and HI/LO are also cleared.
// - Back-to-back divides: the second one starts from IDLE the cycle after DONE. No result is lost.
// - stall_i asserted while the FSM is in DONE: HI/LO are written once. The held div op is not restarted,
//   because a done flag blocks the restart until ID/EX loads a new value.
// TESTING
// - AND 0xF0F0_1234 with 0x0FF0_FFFF, waddr 5 -> next cycle: ex_wdata_o = 0x00F0_1234, waddr 5, wreg 1.
// - SRA of reg1 = 0x8000_0000 by reg2 = 4 -> 0xF800_0000. SLL of 1 by 37 uses 5 bits -> 0x20.
// - DIVU 100 / 7 -> stall_req_o high for 33 cycles; LO = 14, HI = 2; ex_wreg_o = 0 throughout.
// - DIV -7 / 2 -> LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF. DIV 5 / 0 -> 1-cycle stall, LO = 0xFFFF_FFFF, HI = 5.
// - DIVU issued, then flush_i in BUSY cycle 10 -> HI/LO unchanged; next cycle stall_req_o = 0 and EX holds a NOP.
// - OR issued with stall_i held 3 cycles -> outputs stable for 3 cycles. rst pulse -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ex_stage_if.sv
// ID -> EX operand bundle and the EX result bundle that goes to EX/MEM and ID forwarding.
interface ex_stage_if;
    logic [2:0]  id_alusel_i;
    logic [7:0]  id_aluop_i;
    logic [31:0] id_reg1_i;
    logic [31:0] id_reg2_i;
    logic [4:0]  id_waddr_i;
    logic        id_wreg_i;
    logic        ex_wreg_o;
    logic [4:0]  ex_waddr_o;
    logic [31:0] ex_wdata_o;

    modport slave (
        input  id_alusel_i, id_aluop_i, id_reg1_i, id_reg2_i, id_waddr_i, id_wreg_i,
        output ex_wreg_o, ex_waddr_o, ex_wdata_o
    );

    modport master (
        output id_alusel_i, id_aluop_i, id_reg1_i, id_reg2_i, id_waddr_i, id_wreg_i,
        input  ex_wreg_o, ex_waddr_o, ex_wdata_o
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, single-cycle logic/shift unit and a multi-cycle
// radix-2 restoring divider for DIV/DIVU that writes HI/LO.
module ex_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    ex_stage_if.slave   bus,
    output logic        stall_req_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam logic [2:0] ALU_RES_NOP   = 3'b000;
    localparam logic [2:0] ALU_RES_LOGIC = 3'b001;
    localparam logic [2:0] ALU_RES_SHIFT = 3'b010;

    localparam logic [7:0] ALU_NOP_OP  = 8'h00;
    localparam logic [7:0] ALU_AND_OP  = 8'h24;
    localparam logic [7:0] ALU_OR_OP   = 8'h25;
    localparam logic [7:0] ALU_XOR_OP  = 8'h26;
    localparam logic [7:0] ALU_NOR_OP  = 8'h27;
    localparam logic [7:0] ALU_SLL_OP  = 8'h7C;
    localparam logic [7:0] ALU_SRL_OP  = 8'h02;
    localparam logic [7:0] ALU_SRA_OP  = 8'h03;
    localparam logic [7:0] ALU_DIV_OP  = 8'h1A;
    localparam logic [7:0] ALU_DIVU_OP = 8'h1B;

    localparam int              CW       = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } div_state_t;

    // ID/EX pipeline register
    logic [2:0]  alusel_q;
    logic [7:0]  aluop_q;
    logic [31:0] reg1_q;
    logic [31:0] reg2_q;
    logic [4:0]  waddr_q;
    logic        wreg_q;

    logic idex_load;
    assign idex_load = !flush_i && !stall_i && !stall_req_o;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            alusel_q <= ALU_RES_NOP;
            aluop_q  <= ALU_NOP_OP;
            reg1_q   <= '0;
            reg2_q   <= '0;
            waddr_q  <= '0;
            wreg_q   <= 1'b0;
        end else if (idex_load) begin
            alusel_q <= bus.id_alusel_i;
            aluop_q  <= bus.id_aluop_i;
            reg1_q   <= bus.id_reg1_i;
            reg2_q   <= bus.id_reg2_i;
            waddr_q  <= bus.id_waddr_i;
            wreg_q   <= bus.id_wreg_i;
        end
    end

    logic is_div;
    logic is_sdiv;
    assign is_sdiv = (aluop_q == ALU_DIV_OP);
    assign is_div  = is_sdiv || (aluop_q == ALU_DIVU_OP);

    // Single-cycle result path
    logic [31:0] wdata;
    logic [4:0]  shamt;
    assign shamt = reg2_q[4:0];

    always_comb begin
        wdata = '0;
        case (alusel_q)
            ALU_RES_LOGIC: begin
                case (aluop_q)
                    ALU_AND_OP: wdata = reg1_q & reg2_q;
                    ALU_OR_OP:  wdata = reg1_q | reg2_q;
                    ALU_XOR_OP: wdata = reg1_q ^ reg2_q;
                    ALU_NOR_OP: wdata = ~(reg1_q | reg2_q);
                    default:    wdata = '0;
                endcase
            end
            ALU_RES_SHIFT: begin
                case (aluop_q)
                    ALU_SLL_OP: wdata = reg1_q << shamt;
                    ALU_SRL_OP: wdata = reg1_q >> shamt;
                    ALU_SRA_OP: wdata = $signed(reg1_q) >>> shamt;
                    default:    wdata = '0;
                endcase
            end
            default: wdata = '0;
        endcase
    end

    assign bus.ex_wreg_o  = wreg_q && !is_div;
    assign bus.ex_waddr_o = waddr_q;
    assign bus.ex_wdata_o = wdata;

    // Divider
    div_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        dvz_q, dvz_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] partial;
    logic [32:0] diff;

    assign a_abs   = (is_sdiv && reg1_q[31]) ? (~reg1_q + 32'd1) : reg1_q;
    assign b_abs   = (is_sdiv && reg2_q[31]) ? (~reg2_q + 32'd1) : reg2_q;
    assign partial = {rem_q, quo_q[31]};
    assign diff    = partial - {1'b0, dvs_q};

    // done_q blocks a held div op from restarting after its result was written
    assign stall_req_o = ((state_q == S_IDLE) && is_div && !done_q) || (state_q == S_BUSY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dvz_d   = dvz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = done_q;

        case (state_q)
            S_IDLE: begin
                if (is_div && !done_q && !flush_i) begin
                    state_d = (reg2_q == 32'd0) ? S_DONE : S_BUSY;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = a_abs;
                    dvs_d   = b_abs;
                    q_neg_d = is_sdiv && (reg1_q[31] ^ reg2_q[31]);
                    r_neg_d = is_sdiv && reg1_q[31];
                    dvz_d   = (reg2_q == 32'd0);
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (!diff[32]) begin
                        rem_d = diff[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = partial[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!flush_i) begin
                    done_d = 1'b1;
                    if (dvz_q) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = reg1_q;
                    end else begin
                        lo_d = q_neg_q ? (~quo_q + 32'd1) : quo_q;
                        hi_d = r_neg_q ? (~rem_q + 32'd1) : rem_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i || idex_load) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dvz_q   <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dvz_q   <= dvz_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed and randomized checks of ex_stage against an arithmetic reference model.
module tb_ex_stage;
    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic        stall_req_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    ex_stage_if bus();

    ex_stage #(.DIV_CYCLES(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .bus         (bus),
        .stall_req_o (stall_req_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wa, input logic we);
        bus.id_alusel_i = sel;
        bus.id_aluop_i  = op;
        bus.id_reg1_i   = a;
        bus.id_reg2_i   = b;
        bus.id_waddr_i  = wa;
        bus.id_wreg_i   = we;
    endtask

    task automatic drive_nop();
        drive(SEL_NOP, OP_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    // Reference result of a logic/shift op, from plain arithmetic
    function automatic logic [31:0] alu_model(input logic [2:0] sel, input logic [7:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        longint      p2;
        longint      sa;
        longint      q;
        logic [63:0] t;
        p2 = longint'(1) << b[4:0];
        if (sel == SEL_LOGIC) begin
            case (op)
                OP_AND:  return a & b;
                OP_OR:   return a | b;
                OP_XOR:  return a ^ b;
                OP_NOR:  return ~(a | b);
                default: return 32'd0;
            endcase
        end else if (sel == SEL_SHIFT) begin
            case (op)
                OP_SLL: begin t = 64'(longint'({32'd0, a}) * p2); return t[31:0]; end
                OP_SRL: begin t = 64'(longint'({32'd0, a}) / p2); return t[31:0]; end
                OP_SRA: begin
                    sa = longint'($signed(a));
                    q  = sa / p2;
                    if (sa < 0 && (sa % p2) != 0) q = q - 1;
                    t = 64'(q);
                    return t[31:0];
                end
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    // Reference {HI, LO} of a divide
    function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint      na;
        longint      nb;
        logic [63:0] q;
        logic [63:0] r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = 64'(na / nb);
        r = 64'(na % nb);
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check_ex(input string tag, input logic [2:0] sel, input logic [7:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] wa, input logic we);
        chk({tag, "_wdata"}, bus.ex_wdata_o, alu_model(sel, op, a, b));
        chk({tag, "_waddr"}, 32'(bus.ex_waddr_o), 32'(wa));
        chk({tag, "_wreg"}, 32'(bus.ex_wreg_o), 32'(we));
    endtask

    // Counts stall cycles of a div already in EX, checking wreg stays low; bounded.
    task automatic wait_stall_low(input string tag, output int n);
        n = 0;
        while (stall_req_o && n < 100) begin
            chk({tag, "_wreg_low"}, 32'(bus.ex_wreg_o), 32'd0);
            step();
            n++;
        end
    endtask

    // Div op has just entered EX; inputs already set to what follows it.
    task automatic finish_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int          n;
        logic [63:0] r;
        wait_stall_low(tag, n);
        chk({tag, "_stall_cycles"}, 32'(n), (b == 32'd0) ? 32'd1 : 32'd33);
        chk({tag, "_hi_pre"}, hi_o, m_hi);
        step();
        r    = div_model(sgn, a, b);
        m_hi = r[63:32];
        m_lo = r[31:0];
        chk({tag, "_lo"}, lo_o, m_lo);
        chk({tag, "_hi"}, hi_o, m_hi);
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        drive(SEL_NOP, sgn ? OP_DIV : OP_DIVU, a, b, 5'd4, 1'b1);
        step();
        drive_nop();
        finish_div(tag, sgn, a, b);
    endtask

    initial begin
        int          n;
        logic [7:0]  ops [9];
        logic [2:0]  sel;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wa;
        logic        we;
        logic [63:0] r;
        ops = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_DIV, OP_DIVU};

        // Reset state
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        drive_nop();
        step(); step();
        rst = 1'b0;
        chk("rst_wreg", 32'(bus.ex_wreg_o), 32'd0);
        chk("rst_waddr", 32'(bus.ex_waddr_o), 32'd0);
        chk("rst_wdata", bus.ex_wdata_o, 32'd0);
        chk("rst_stall", 32'(stall_req_o), 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);

        // Logic and shift directed cases
        drive(SEL_LOGIC, OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd5, 1'b1);
        step();
        chk("and_wdata", bus.ex_wdata_o, 32'h00F0_1234);
        chk("and_waddr", 32'(bus.ex_waddr_o), 32'd5);
        chk("and_wreg", 32'(bus.ex_wreg_o), 32'd1);
        drive(SEL_SHIFT, OP_SRA, 32'h8000_0000, 32'd4, 5'd6, 1'b1);
        step();
        chk("sra_wdata", bus.ex_wdata_o, 32'hF800_0000);
        drive(SEL_SHIFT, OP_SLL, 32'd1, 32'd37, 5'd7, 1'b1);
        step();
        chk("sll37_wdata", bus.ex_wdata_o, 32'h0000_0020);
        drive(SEL_NOP, OP_OR, 32'h1234_5678, 32'h1, 5'd8, 1'b1);
        step();
        chk("nopsel_wdata", bus.ex_wdata_o, 32'd0);

        // Divides
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        chk("divu_lo_const", lo_o, 32'd14);
        chk("divu_hi_const", hi_o, 32'd2);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_lo_const", lo_o, 32'hFFFF_FFFD);
        chk("div_m7_hi_const", hi_o, 32'hFFFF_FFFF);
        run_div("div_5_0", 1'b1, 32'd5, 32'd0);
        chk("div0_lo_const", lo_o, 32'hFFFF_FFFF);
        chk("div0_hi_const", hi_o, 32'd5);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divmin_lo_const", lo_o, 32'h8000_0000);
        chk("divmin_hi_const", hi_o, 32'd0);

        // Flush in BUSY cycle 10
        drive(SEL_NOP, OP_DIVU, 32'd1000, 32'd3, 5'd9, 1'b1);
        step();
        drive_nop();
        step();
        repeat (10) step();
        chk("flush_pre_stall", 32'(stall_req_o), 32'd1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_stall", 32'(stall_req_o), 32'd0);
        chk("flush_waddr", 32'(bus.ex_waddr_o), 32'd0);
        chk("flush_wdata", bus.ex_wdata_o, 32'd0);
        repeat (3) step();
        chk("flush_stall_later", 32'(stall_req_o), 32'd0);
        chk("flush_hi", hi_o, m_hi);
        chk("flush_lo", lo_o, m_lo);

        // OR held by stall_i for 3 cycles
        drive(SEL_LOGIC, OP_OR, 32'hA000_0001, 32'h0500_0010, 5'd11, 1'b1);
        step();
        drive(SEL_LOGIC, OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd12, 1'b1);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_ex("or_held", SEL_LOGIC, OP_OR, 32'hA000_0001, 32'h0500_0010, 5'd11, 1'b1);
        end
        stall_i = 1'b0;
        step();
        check_ex("xor_after_hold", SEL_LOGIC, OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd12, 1'b1);

        // stall_i held across DONE: one write, no restart
        drive(SEL_NOP, OP_DIVU, 32'd1000, 32'd7, 5'd3, 1'b1);
        step();
        drive_nop();
        wait_stall_low("dstall", n);
        chk("dstall_cycles", 32'(n), 32'd33);
        stall_i = 1'b1;
        step();
        r = div_model(1'b0, 32'd1000, 32'd7);
        m_hi = r[63:32]; m_lo = r[31:0];
        chk("dstall_lo", lo_o, m_lo);
        chk("dstall_hi", hi_o, m_hi);
        step(); step();
        chk("dstall_no_restart", 32'(stall_req_o), 32'd0);
        chk("dstall_held_waddr", 32'(bus.ex_waddr_o), 32'd3);
        stall_i = 1'b0;
        step();
        chk("dstall_release_waddr", 32'(bus.ex_waddr_o), 32'd0);
        chk("dstall_release_stall", 32'(stall_req_o), 32'd0);

        // Back-to-back divides
        drive(SEL_NOP, OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd1, 1'b0);
        step();
        drive(SEL_NOP, OP_DIVU, 32'd50, 32'd4, 5'd2, 1'b0);
        wait_stall_low("b2b_first", n);
        chk("b2b_first_cycles", 32'(n), 32'd33);
        step();
        drive_nop();
        r = div_model(1'b1, 32'hFFFF_FF9C, 32'd7);
        m_hi = r[63:32]; m_lo = r[31:0];
        chk("b2b_first_lo", lo_o, m_lo);
        chk("b2b_first_hi", hi_o, m_hi);
        chk("b2b_second_stall", 32'(stall_req_o), 32'd1);
        finish_div("b2b_second", 1'b0, 32'd50, 32'd4);

        // Reset mid-division
        drive(SEL_NOP, OP_DIVU, 32'd999, 32'd5, 5'd4, 1'b1);
        step();
        drive_nop();
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        chk("rstdiv_stall", 32'(stall_req_o), 32'd0);
        chk("rstdiv_hi", hi_o, m_hi);
        chk("rstdiv_lo", lo_o, m_lo);
        chk("rstdiv_waddr", 32'(bus.ex_waddr_o), 32'd0);

        // Reset pulse after an OR
        drive(SEL_LOGIC, OP_OR, 32'h0000_00F0, 32'h0000_000F, 5'd13, 1'b1);
        step();
        chk("or_pre_rst", bus.ex_wdata_o, 32'h0000_00FF);
        rst = 1'b1;
        step();
        chk("rstpulse_wdata", bus.ex_wdata_o, 32'd0);
        chk("rstpulse_wreg", 32'(bus.ex_wreg_o), 32'd0);
        chk("rstpulse_waddr", 32'(bus.ex_waddr_o), 32'd0);
        rst = 1'b0;
        drive_nop();
        step();

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            op = ops[$urandom_range(0, 8)];
            a  = $urandom();
            b  = $urandom();
            wa = 5'($urandom_range(0, 31));
            we = 1'($urandom_range(0, 1));
            if (op == OP_DIV || op == OP_DIVU) begin
                if ($urandom_range(0, 4) == 0) b = 32'd0;
                else if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 20));
                run_div("rnd_div", op == OP_DIV, a, b);
            end else begin
                sel = (op == OP_SLL || op == OP_SRL || op == OP_SRA) ? SEL_SHIFT : SEL_LOGIC;
                drive(sel, op, a, b, wa, we);
                step();
                check_ex("rnd_alu", sel, op, a, b, wa, we);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
